ahb_fifo_write: RTL and testbench
=================================

Name: ahb_fifo_write

Overview:
- AHB-Lite slave that turns CPU write transfers into a 16-bit valid/ready stream, for example pixel or command words toward the LCD printer path.
- A small internal FIFO lets writes complete with zero wait states until it fills; after that the data phase stalls via HREADYOUT.
- Read transfers return a status word (level, full, empty) so software can poll instead of stalling.
- Complements the FIFO-read slave, which drains a stream into HRDATA.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- HSEL  in  1  slave select.
- HWRITE  in  1  1 = write transfer.
- HREADY  in  1  bus ready (previous transfer complete).
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HADDR  in  32  address; only bit 1 is used (halfword lane).
- HWDATA  in  32  write data, valid in data phase.
- HREADYOUT  out  1  0 = stall data phase.
- HRDATA  out  32  status word for reads.
- HRESP  out  1  tied 0 (always OKAY).
- data_out_vld  out  1  FIFO head valid.
- data_out  out  16  FIFO head word.
- data_out_rdy  in  1  downstream accepts head.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, no pending data phase; HREADYOUT=1, data_out_vld=0, HRDATA=0. Storage array not reset. data_out is don't-care while data_out_vld=0.
- Address phase accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register pend=1, pend_wr=HWRITE, pend_hi=HADDR[1]. Otherwise pend=0. A non-selected or IDLE/BUSY transfer clears pend only when HREADY=1.
- Write data phase (pend & pend_wr):
  - Selected halfword is HWDATA[31:16] when pend_hi=1, else HWDATA[15:0].
  - push_ok = (count < DEPTH) | pop, where pop = data_out_vld & data_out_rdy in the same cycle. A pop frees a slot for a same-cycle push, so the path from data_out_rdy to HREADYOUT is combinational.
  - HREADYOUT = push_ok. Push occurs in the cycle HREADYOUT=1. While stalled, the next address phase is held off by the master (HREADY=0), so pend stays set.
- Read data phase (pend & !pend_wr):
  - Zero wait, HREADYOUT=1.
  - HRDATA[AW:0] = count at that cycle; HRDATA[16] = full; HRDATA[17] = empty; all other bits 0.
  - HRDATA = 0 outside read data phases. No FIFO side effect.
- Stream side:
  - data_out_vld = (count != 0); data_out = mem[rd_ptr].
  - Pop on data_out_vld & data_out_rdy; rd_ptr increments with wrap at DEPTH.
  - First-word latency: a word pushed at edge N is visible with data_out_vld=1 in cycle N+1.
- Count rules:
  - count is AW+1 bits; +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers are AW bits and wrap naturally.
  - count never exceeds DEPTH and never underflows.
- Simultaneous push and pop when empty: not possible, because vld=0 when empty; the push lands and vld rises next cycle.
- Back-to-back writes: each data phase overlaps the next address phase. Sustained throughput is one halfword per cycle while not full.
- Reset during stall: pend clears, HREADYOUT returns to 1, stalled word is dropped, FIFO contents discarded.
- HRESP is always 0. HSIZE is not decoded; every write is treated as a halfword to the lane selected by HADDR[1].

Decomposition:
- Shared package lcd_pkg: status bit constants STAT_FULL_BIT=16, STAT_EMPTY_BIT=17, and the HTRANS NONSEQ/SEQ bit index.
- One sub-module is natural: sync_fifo16, covering storage, pointers, count, full/empty and push/pop, parameterised by DEPTH. The top holds the AHB phase register, lane mux, stall logic and status mux.

Test Plan:
- Single write HADDR=0x0, HWDATA=0x1234ABCD, data_out_rdy=1 → HREADYOUT stays 1; next cycle data_out_vld=1, data_out=0xABCD; popped, FIFO empty.
- Write HADDR=0x2, HWDATA=0x1234ABCD → data_out=0x1234.
- data_out_rdy=0, 5 back-to-back writes (DEPTH=4) of 1..5 → first 4 zero-wait; 5th data phase HREADYOUT=0. Raise data_out_rdy → 5th completes in the pop cycle; stream order 1,2,3,4,5.
- Read after 3 writes with data_out_rdy=0 → HRDATA=0x00000003. Read when empty → 0x00020000. Read when full → 0x00010004.
- Sustained writes with data_out_rdy=1 every cycle → no stalls, count never exceeds 1, all words delivered in order.
- Assert rst while stalled on a full FIFO → HREADYOUT=1 and data_out_vld=0 immediately. After release, a status read returns 0x00020000.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, payload types and helpers for the LCD-path AHB stream slaves.
// No ports; imported by the interface, FIFO and top.
package lcd_pkg;

  localparam int unsigned BUS_W          = 32;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned STAT_FULL_BIT  = 16;
  localparam int unsigned STAT_EMPTY_BIT = 17;
  // HTRANS bit that distinguishes NONSEQ/SEQ from IDLE/BUSY
  localparam int unsigned HTRANS_ACT_BIT = 1;

  // Captured address-phase attributes, consumed in the following data phase
  typedef struct packed {
    logic vld;
    logic wr;
    logic hi;
  } ahb_pend_t;

  // Halfword lane selected by HADDR[1]
  function automatic logic [DATA_W-1:0] lane_sel(input logic [BUS_W-1:0] wdata,
                                                 input logic             hi);
    return hi ? wdata[BUS_W-1:DATA_W] : wdata[DATA_W-1:0];
  endfunction

  // Status word: low bits = level, plus full/empty flags
  function automatic logic [BUS_W-1:0] status_word(input logic [BUS_W-1:0] level,
                                                   input logic             full,
                                                   input logic             empty);
    logic [BUS_W-1:0] w;
    w                 = level;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    return w;
  endfunction

endpackage

// File: rtl/ahb_fifo_write_if.sv
// AHB-Lite slave bus plus outgoing 16-bit valid/ready stream.
// slave modport: DUT view; master modport: bus master + stream sink view.
interface ahb_fifo_write_if;
  import lcd_pkg::*;

  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [BUS_W-1:0]  HADDR;
  logic [BUS_W-1:0]  HWDATA;
  logic              HREADYOUT;
  logic [BUS_W-1:0]  HRDATA;
  logic              HRESP;
  logic              data_out_vld;
  logic [DATA_W-1:0] data_out;
  logic              data_out_rdy;

  modport slave (
    input  HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, data_out_rdy,
    output HREADYOUT, HRDATA, HRESP, data_out_vld, data_out
  );

  modport master (
    output HSEL, HWRITE, HREADY, HTRANS, HADDR, HWDATA, data_out_rdy,
    input  HREADYOUT, HRDATA, HRESP, data_out_vld, data_out
  );

endinterface

// File: rtl/ahb_fifo_write_sync_fifo16.sv
// Synchronous 16-bit FIFO with level/full/empty and push/pop.
// Ports: clk, rst (async, active-high), push/push_data, pop, head (mem[rd_ptr]),
//        count (AW+1 bits), full, empty.
module sync_fifo16
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  // Guard against illegal requests; a same-cycle pop frees a slot for the push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr];

  // Storage carries no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ahb_fifo_write.sv
// AHB-Lite write slave feeding a 16-bit valid/ready stream through a small FIFO.
// Writes complete zero-wait until the FIFO is full, then stall via HREADYOUT.
// Reads return status {empty@17, full@16, level@[AW:0]} with no side effect.
// Ports: clk, rst (async, active-high), bus (ahb_fifo_write_if.slave).
module ahb_fifo_write
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ahb_fifo_write_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ahb_pend_t         pend_q;
  ahb_pend_t         pend_d;
  logic              addr_acc;
  logic              wr_phase;
  logic              rd_phase;
  logic              pop;
  logic              push_ok;
  logic              push;
  logic [DATA_W-1:0] wr_half;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              unused_bus_bits;

  assign unused_bus_bits = ^{bus.HADDR[BUS_W-1:2], bus.HADDR[0], bus.HTRANS[0]};

  assign addr_acc = bus.HSEL & bus.HTRANS[HTRANS_ACT_BIT] & bus.HREADY;

  // Address-phase capture; held while the bus is stalled (HREADY=0)
  always_comb begin
    pend_d = pend_q;
    if (bus.HREADY) begin
      pend_d.vld = addr_acc;
      pend_d.wr  = bus.HWRITE;
      pend_d.hi  = bus.HADDR[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign wr_phase = pend_q.vld & pend_q.wr;
  assign rd_phase = pend_q.vld & ~pend_q.wr;

  // Same-cycle pop frees a slot, so data_out_rdy reaches HREADYOUT combinationally
  assign pop     = ~empty & bus.data_out_rdy;
  assign push_ok = ~full | pop;
  assign push    = wr_phase & push_ok;
  assign wr_half = lane_sel(bus.HWDATA, pend_q.hi);

  sync_fifo16 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_half),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.HREADYOUT    = wr_phase ? push_ok : 1'b1;
  assign bus.HRESP        = 1'b0;
  assign bus.HRDATA       = rd_phase ? status_word(BUS_W'(count), full, empty) : '0;
  assign bus.data_out_vld = ~empty;
  assign bus.data_out     = head;

endmodule

// File: tb/tb_ahb_fifo_write.sv
// Directed self-checking bench for ahb_fifo_write (DEPTH=4).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_ahb_fifo_write;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ahb_fifo_write_if bus_if ();

  // Single-slave system: bus HREADY follows this slave's HREADYOUT
  assign bus_if.HREADY = bus_if.HREADYOUT;

  ahb_fifo_write #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic addr(input logic wr, input logic [31:0] a);
    bus_if.HSEL   = 1'b1;
    bus_if.HTRANS = 2'b10;
    bus_if.HWRITE = wr;
    bus_if.HADDR  = a;
  endtask

  task automatic noaddr();
    bus_if.HSEL   = 1'b0;
    bus_if.HTRANS = 2'b00;
    bus_if.HWRITE = 1'b0;
    bus_if.HADDR  = 32'h0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    noaddr();
    bus_if.HWDATA       = 32'h0;
    bus_if.data_out_rdy = 1'b0;

    // Reset state
    #12;
    chk("rst_hreadyout", 32'(bus_if.HREADYOUT), 32'd1);
    chk("rst_vld",       32'(bus_if.data_out_vld), 32'd0);
    chk("rst_hrdata",    bus_if.HRDATA, 32'h0);
    chk("rst_hresp",     32'(bus_if.HRESP), 32'd0);
    nxt(); rst = 1'b0;

    // Single write, low lane
    bus_if.data_out_rdy = 1'b1;
    nxt(); addr(1'b1, 32'h0);
    nxt(); noaddr(); bus_if.HWDATA = 32'h1234ABCD; #1;
    chk("w1_hreadyout", 32'(bus_if.HREADYOUT), 32'd1);
    chk("w1_vld_before", 32'(bus_if.data_out_vld), 32'd0);
    nxt(); #1;
    chk("w1_vld",  32'(bus_if.data_out_vld), 32'd1);
    chk("w1_data", 32'(bus_if.data_out), 32'h0000ABCD);
    nxt(); #1;
    chk("w1_empty", 32'(bus_if.data_out_vld), 32'd0);

    // Single write, high lane
    nxt(); addr(1'b1, 32'h2);
    nxt(); noaddr(); bus_if.HWDATA = 32'h1234ABCD; #1;
    chk("w2_hreadyout", 32'(bus_if.HREADYOUT), 32'd1);
    nxt(); #1;
    chk("w2_data", 32'(bus_if.data_out), 32'h00001234);
    nxt(); #1;
    chk("w2_empty", 32'(bus_if.data_out_vld), 32'd0);

    // Five back-to-back writes into a DEPTH=4 FIFO with sink stalled
    bus_if.data_out_rdy = 1'b0;
    nxt(); addr(1'b1, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      nxt(); addr(1'b1, 32'h0); bus_if.HWDATA = 32'(k); #1;
      chk($sformatf("b2b_zero_wait_%0d", k), 32'(bus_if.HREADYOUT), 32'd1);
    end
    nxt(); noaddr(); bus_if.HWDATA = 32'd5; #1;
    chk("b2b_stall_a", 32'(bus_if.HREADYOUT), 32'd0);
    chk("b2b_head",    32'(bus_if.data_out), 32'd1);
    nxt(); #1;
    chk("b2b_stall_b", 32'(bus_if.HREADYOUT), 32'd0);
    nxt(); bus_if.data_out_rdy = 1'b1; #1;
    chk("b2b_release", 32'(bus_if.HREADYOUT), 32'd1);
    chk("b2b_pop_1",   32'(bus_if.data_out), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      nxt(); #1;
      chk($sformatf("b2b_order_%0d", k), 32'(bus_if.data_out), 32'(k));
      chk($sformatf("b2b_vld_%0d", k), 32'(bus_if.data_out_vld), 32'd1);
    end
    nxt(); #1;
    chk("b2b_drained", 32'(bus_if.data_out_vld), 32'd0);

    // Status reads: empty, level 3, full
    bus_if.data_out_rdy = 1'b0;
    nxt(); addr(1'b0, 32'h0);
    nxt(); addr(1'b1, 32'h0); #1;
    chk("rd_empty", bus_if.HRDATA, 32'h00020000);
    nxt(); addr(1'b1, 32'h0); bus_if.HWDATA = 32'h00000011; #1;
    chk("rd_idle_in_wr", bus_if.HRDATA, 32'h0);
    nxt(); addr(1'b1, 32'h0); bus_if.HWDATA = 32'h00000022;
    nxt(); addr(1'b0, 32'h0); bus_if.HWDATA = 32'h00000033;
    nxt(); noaddr(); #1;
    chk("rd_level3", bus_if.HRDATA, 32'h00000003);
    chk("rd_level3_nostall", 32'(bus_if.HREADYOUT), 32'd1);
    nxt(); #1;
    chk("rd_outside", bus_if.HRDATA, 32'h0);
    addr(1'b1, 32'h0);
    nxt(); addr(1'b0, 32'h0); bus_if.HWDATA = 32'h00000044; #1;
    chk("fill_4th", 32'(bus_if.HREADYOUT), 32'd1);
    nxt(); noaddr(); #1;
    chk("rd_full", bus_if.HRDATA, 32'h00010004);
    chk("head_after_reads", 32'(bus_if.data_out), 32'h00000011);

    // Reset while stalled on a full FIFO
    nxt(); addr(1'b1, 32'h0);
    nxt(); noaddr(); bus_if.HWDATA = 32'h00000055; #1;
    chk("rst_stall_pre", 32'(bus_if.HREADYOUT), 32'd0);
    rst = 1'b1; #1;
    chk("rst_stall_hro", 32'(bus_if.HREADYOUT), 32'd1);
    chk("rst_stall_vld", 32'(bus_if.data_out_vld), 32'd0);
    nxt(); rst = 1'b0; addr(1'b0, 32'h0);
    nxt(); noaddr(); #1;
    chk("rst_stall_status", bus_if.HRDATA, 32'h00020000);

    // Sustained writes with sink always ready, alternating lanes
    bus_if.data_out_rdy = 1'b1;
    nxt(); addr(1'b1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      nxt();
      if (k < 7) addr(1'b1, ((k + 1) % 2 == 1) ? 32'h2 : 32'h0);
      else       addr(1'b0, 32'h0);
      w = 16'hA0 + 16'(k);
      bus_if.HWDATA = (k % 2 == 1) ? {w, 16'hDEAD} : {16'hBEEF, w};
      #1;
      chk($sformatf("sus_hro_%0d", k), 32'(bus_if.HREADYOUT), 32'd1);
      if (k > 0) begin
        chk($sformatf("sus_data_%0d", k - 1), 32'(bus_if.data_out), 32'h000000A0 + 32'(k - 1));
      end
    end
    nxt(); noaddr(); #1;
    chk("sus_level_le1", bus_if.HRDATA, 32'h00000001);
    chk("sus_data_7", 32'(bus_if.data_out), 32'h000000A7);
    nxt(); #1;
    chk("sus_drained", 32'(bus_if.data_out_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
